// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the fetch front end.
// Contents: fetch FSM states, redirect source encoding, instruction width/size.
// Imported by fetch_ctrl and fetch_redirect_mux.
package riscv_pkg;

  localparam int          ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    RD_NONE    = 2'd0,
    RD_TRAP    = 2'd1,
    RD_MISPRED = 2'd2,
    RD_FENCE   = 2'd3
  } redirect_src_e;

endpackage

// File: rtl/fetch_redirect_mux.sv
// fetch_redirect_mux: priority select of the redirect target (trap > mispredict > fence.i).
// Latency: purely combinational.
// Backpressure: none; redirect sources are single-cycle pulses.
// Ports: trap/t_addr, mispred/r_addr, fence_i/fence_addr in; redirect, redirect_src, target out.
module fetch_redirect_mux
  import riscv_pkg::*;
(
  input  logic        trap,
  input  logic [31:0] t_addr,
  input  logic        mispred,
  input  logic [31:0] r_addr,
  input  logic        fence_i,
  input  logic [31:0] fence_addr,
  output logic        redirect,
  output logic [1:0]  redirect_src,
  output logic [31:0] target
);

  always_comb begin
    redirect     = trap | mispred | fence_i;
    redirect_src = RD_NONE;
    target       = '0;
    if (trap) begin
      redirect_src = RD_TRAP;
      target       = t_addr;
    end else if (mispred) begin
      redirect_src = RD_MISPRED;
      target       = r_addr;
    end else if (fence_i) begin
      // fence.i resumes at the instruction after itself; wraps modulo 2^32
      redirect_src = RD_FENCE;
      target       = fence_addr + 32'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, issues imem requests and hands {addr, instr} pairs to decode.
// Latency: single outstanding request; response lands in the output register next edge; peak 1 instr / 2 cycles.
// Backpressure: if_ready low parks the pair in HOLD and no new imem request is issued until it drains.
// Ports: redirect inputs (trap/mispred/fence_i + targets), predictor (pc out, bp_taken/bp_addr in),
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata, if_valid/if_ready/if_addr/if_instr, perf_* out.
// Optional: FETCH_CTRL_PERF_EN adds 32-bit saturating perf counters; otherwise perf_* are tied to 0.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap,
  input  logic [31:0] t_addr,
  input  logic        mispred,
  input  logic [31:0] r_addr,
  input  logic        fence_i,
  input  logic [31:0] fence_addr,
  input  logic        bp_taken,
  input  logic [31:0] bp_addr,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_addr,
  output logic [31:0] if_instr,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_redirect,
  output logic [31:0] perf_stall
);

  fetch_state_e      state, state_nxt;
  logic [ILEN-1:0]   req_pc;
  logic              drop;
  logic              redirect;
  logic [1:0]        redirect_src;
  logic [31:0]       target;
  logic              issue;
  logic              load;

  fetch_redirect_mux u_redirect_mux (
    .trap         (trap),
    .t_addr       (t_addr),
    .mispred      (mispred),
    .r_addr       (r_addr),
    .fence_i      (fence_i),
    .fence_addr   (fence_addr),
    .redirect     (redirect),
    .redirect_src (redirect_src),
    .target       (target)
  );

  always_comb begin
    assert (redirect == (redirect_src != RD_NONE));
  end

  // imem_req only asserts in REQ, so a handshake implies REQ
  assign issue = imem_req && imem_gnt;
  // A response is kept only if no redirect made it stale (earlier or this cycle)
  assign load  = (state == WAIT) && imem_rvalid && !drop && !redirect;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (issue) state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (drop || redirect) state_nxt = REQ;
          // The output register is always empty in WAIT (requests only go out while it
          // is empty or draining), so decode readiness alone decides whether to park.
          else if (if_ready)    state_nxt = REQ;
          else                  state_nxt = HOLD;
        end
      end
      HOLD: if (if_ready || redirect) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the request is gated so it never goes out while a pair is stuck in the output register
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (state == REQ) imem_req = !if_valid || if_ready;
  end

  // Datapath: pc, in-flight bookkeeping, output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_addr  <= '0;
      if_instr <= '0;
    end else begin
      if (redirect)   pc <= {target[31:2], 2'b00};
      else if (issue) pc <= bp_taken ? bp_addr : pc + 32'(INSTR_BYTES);

      if (issue) req_pc <= pc;

      if (state == WAIT) begin
        if (imem_rvalid)   drop <= 1'b0;
        else if (redirect) drop <= 1'b1;
      end else if (issue && redirect) begin
        drop <= 1'b1;
      end

      if (redirect)      if_valid <= 1'b0;
      else if (load)     if_valid <= 1'b1;
      else if (if_ready) if_valid <= 1'b0;

      if (load) begin
        if_addr  <= req_pc;
        if_instr <= imem_rdata;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt, redirect_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (if_valid && if_ready && fetch_cnt != '1)  fetch_cnt    <= fetch_cnt + 32'd1;
      if (redirect && redirect_cnt != '1)           redirect_cnt <= redirect_cnt + 32'd1;
      if (if_valid && !if_ready && stall_cnt != '1) stall_cnt    <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch    = fetch_cnt;
  assign perf_redirect = redirect_cnt;
  assign perf_stall    = stall_cnt;
`else
  assign perf_fetch    = '0;
  assign perf_redirect = '0;
  assign perf_stall    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a one-deep instruction memory model.
// Memory grants every request immediately and answers on the following cycle unless held off.
// Expected addresses/instructions are hand-derived; instruction = address ^ constant.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap, mispred, fence_i;
  logic [31:0] t_addr, r_addr, fence_addr;
  logic        bp_taken;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_addr, if_instr;
  logic [31:0] perf_fetch, perf_redirect, perf_stall;

  int n_chk  = 0;
  int n_fail = 0;
  int bad_vld = 0;

  // memory model controls
  logic        gnt_en  = 1'b1;
  logic        resp_en = 1'b1;
  logic        ovr_en  = 1'b0;
  logic [31:0] ovr_dat = 32'h0;
  logic        pend    = 1'b0;
  logic [31:0] paddr   = 32'h0;

  // predictor model
  logic        bp_en    = 1'b0;
  logic [31:0] bp_match = 32'h0;
  logic [31:0] bp_tgt   = 32'h0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .trap          (trap),
    .t_addr        (t_addr),
    .mispred       (mispred),
    .r_addr        (r_addr),
    .fence_i       (fence_i),
    .fence_addr    (fence_addr),
    .bp_taken      (bp_taken),
    .bp_addr       (bp_addr),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_addr       (if_addr),
    .if_instr      (if_instr),
    .perf_fetch    (perf_fetch),
    .perf_redirect (perf_redirect),
    .perf_stall    (perf_stall)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bp_taken    = bp_en && (pc == bp_match);
  assign bp_addr     = bp_tgt;
  assign imem_gnt    = gnt_en && imem_req;
  assign imem_rvalid = pend && resp_en;
  assign imem_rdata  = ovr_en ? ovr_dat : instr_of(paddr);

  always @(posedge clk) begin
    if (imem_rvalid) pend <= 1'b0;
    if (imem_gnt) begin
      pend  <= 1'b1;
      paddr <= imem_addr;
    end
  end

  always @(negedge clk) begin
    if (if_valid && if_instr == 32'h0000_DEAD) bad_vld = bad_vld + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Wait (from the current negedge) for a decode handshake and check the pair
  task automatic wait_fetch(input string tag, input logic [31:0] ea);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (if_valid && if_ready) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) chk({tag, "_timeout"}, {31'd0, hit}, 32'd1);
    else begin
      chk({tag, "_addr"}, if_addr, ea);
      chk({tag, "_instr"}, if_instr, instr_of(ea));
    end
    @(negedge clk);
  endtask

  // Wait (from the current negedge) for the next imem request and check its address
  task automatic wait_req(input string tag, input logic [31:0] ea);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_req) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) chk({tag, "_timeout"}, {31'd0, hit}, 32'd1);
    else chk(tag, imem_addr, ea);
  endtask

  task automatic pulse(input logic tr, input logic mp, input logic fi,
                       input logic [31:0] ta, input logic [31:0] ra, input logic [31:0] fa);
    trap = tr; mispred = mp; fence_i = fi;
    t_addr = ta; r_addr = ra; fence_addr = fa;
    @(negedge clk);
    trap = 1'b0; mispred = 1'b0; fence_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_vld"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_perf_fetch"}, perf_fetch, 32'd0);
    chk({tag, "_perf_redirect"}, perf_redirect, 32'd0);
    chk({tag, "_perf_stall"}, perf_stall, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trap = 1'b0; mispred = 1'b0; fence_i = 1'b0;
    t_addr = '0; r_addr = '0; fence_addr = '0; if_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk_reset("rst");
    chk("rst_if_addr", if_addr, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    rst = 1'b0;

    // 1: sequential fetch, then wrap through 0xFFFF_FFFC
    wait_fetch("t1_f0", 32'h0);
    wait_fetch("t1_f4", 32'h4);
    wait_fetch("t1_f8", 32'h8);
    wait_fetch("t1_fc", 32'hC);
    pulse(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    chk("t1_trap_pc", pc, 32'hFFFF_FFFC);
    wait_fetch("t1_top", 32'hFFFF_FFFC);
    wait_fetch("t1_wrap", 32'h0);

    // 2: predictor taken at pc=0x8 -> 0x100
    bp_en = 1'b1; bp_match = 32'h8; bp_tgt = 32'h100;
    wait_fetch("t2_f4", 32'h4);
    wait_fetch("t2_f8", 32'h8);
    wait_fetch("t2_tgt", 32'h100);
    bp_en = 1'b0;

    // 3: mispredict while waiting; late response 0xDEAD must vanish
    resp_en = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0);
    chk("t3_pc", pc, 32'h200);
    ovr_en = 1'b1; ovr_dat = 32'h0000_DEAD; resp_en = 1'b1;
    @(negedge clk);
    ovr_en = 1'b0;
    wait_req("t3_addr", 32'h200);
    wait_fetch("t3_f", 32'h200);
    chk("t3_no_dead", bad_vld, 32'd0);

    // 4: all three redirects at once, trap wins
    pulse(1'b1, 1'b1, 1'b1, 32'h80, 32'h40, 32'h3C);
    chk("t4_pc", pc, 32'h80);
    wait_req("t4_addr", 32'h80);
    wait_fetch("t4_f", 32'h80);

    // 5: fence.i while parked in HOLD
    if_ready = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (if_valid) seen = 1'b1;
        else @(negedge clk);
      end
      chk("t5_hold_vld", {31'd0, if_valid}, 32'd1);
    end
    chk("t5_hold_addr", if_addr, 32'h84);
    repeat (2) @(negedge clk);
    chk("t5_stable_addr", if_addr, 32'h84);
    chk("t5_stable_instr", if_instr, instr_of(32'h84));
    chk("t5_no_req", {31'd0, imem_req}, 32'd0);
    pulse(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h3C);
    chk("t5_vld_drop", {31'd0, if_valid}, 32'd0);
    chk("t5_pc", pc, 32'h40);
    chk("t5_req", {31'd0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr, 32'h40);
    if_ready = 1'b1;
    wait_fetch("t5_f", 32'h40);

    // 6: reset while waiting, response lands right after reset
    resp_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; resp_en = 1'b1;
    chk_reset("t6_rst");
    wait_req("t6_addr", 32'h0);
    wait_fetch("t6_f", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
